// File: rtl/uart_mem_host.sv
// Host-side peer of the processor UART memory link: streams a source RAM image out
// as a load, then captures the returned dump into a capture RAM (LSB-first framing).
module uart_mem_host #(
  parameter int MEM_WORD_LENGTH = 12,
  parameter int MEM_DEPTH       = 4096,
  parameter int MEM_ADDR_LENGTH = $clog2(MEM_DEPTH),
  parameter int UART_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_en,
  input  logic [MEM_ADDR_LENGTH-1:0] load_end_addr,
  input  logic [MEM_ADDR_LENGTH-1:0] dump_end_addr,
  output logic                       busy,
  output logic                       load_done,
  output logic                       dump_done,
  output logic                       timeout_err,
  output logic [MEM_ADDR_LENGTH-1:0] srcAddr,
  input  logic [MEM_WORD_LENGTH-1:0] srcData,
  output logic                       capWrEn,
  output logic [MEM_ADDR_LENGTH-1:0] capAddr,
  output logic [MEM_WORD_LENGTH-1:0] capData,
  input  logic                       txByteReady,
  output logic                       txByteStart,
  output logic [UART_WIDTH-1:0]      byteForTx,
  input  logic                       rxByteReady,
  input  logic                       rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0]      byteFromRx,
  output logic [3:0]                 dbg_state
);

  localparam int BPW = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int SHW = BPW * UART_WIDTH;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [IW-1:0]              LAST_IDX = IW'(BPW - 1);
  localparam logic [IW-1:0]              IDX_ONE  = IW'(1);
  localparam logic [TW-1:0]              TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]              TMO_ONE  = TW'(1);
  localparam logic [MEM_ADDR_LENGTH-1:0] ADDR_ONE = MEM_ADDR_LENGTH'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LD_ADDR  = 4'd1;
  localparam logic [3:0] S_LD_WAIT  = 4'd2;
  localparam logic [3:0] S_LD_LATCH = 4'd3;
  localparam logic [3:0] S_TX_START = 4'd4;
  localparam logic [3:0] S_TX_BUSY  = 4'd5;
  localparam logic [3:0] S_TX_DONE  = 4'd6;
  localparam logic [3:0] S_DUMP     = 4'd7;
  localparam logic [3:0] S_CAP_WR   = 4'd8;

  logic [3:0]                 r_state;
  logic [MEM_ADDR_LENGTH-1:0] r_src_addr;
  logic [MEM_ADDR_LENGTH-1:0] r_cap_addr;
  logic [SHW-1:0]             r_tx_shift;
  logic [IW-1:0]              r_tx_idx;
  logic [SHW-1:0]             r_rx_word;
  logic [IW-1:0]              r_rx_idx;
  logic [TW-1:0]              r_tmo;
  logic                       r_load_done;
  logic                       r_timeout_err;
  logic                       w_cap_wr;
  logic                       w_unused;

  // TX handshake: the start strobe is only raised while the UART reports idle,
  // and the byte on byteForTx only changes after TX has gone busy and come back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_src_addr    <= '0;
      r_cap_addr    <= '0;
      r_tx_shift    <= '0;
      r_tx_idx      <= '0;
      r_rx_word     <= '0;
      r_rx_idx      <= '0;
      r_tmo         <= '0;
      r_load_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= load_en ? S_LD_ADDR : S_DUMP;
            r_src_addr    <= '0;
            r_cap_addr    <= '0;
            r_tx_idx      <= '0;
            r_rx_idx      <= '0;
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        S_LD_ADDR:  r_state <= S_LD_WAIT;
        S_LD_WAIT:  r_state <= S_LD_LATCH;
        S_LD_LATCH: begin
          r_tx_shift <= SHW'(srcData);
          r_tx_idx   <= '0;
          r_state    <= S_TX_START;
        end
        S_TX_START: if (txByteReady) r_state <= S_TX_BUSY;
        S_TX_BUSY:  if (!txByteReady) r_state <= S_TX_DONE;
        S_TX_DONE: begin
          if (txByteReady) begin
            if (r_tx_idx != LAST_IDX) begin
              r_tx_shift <= r_tx_shift >> UART_WIDTH;
              r_tx_idx   <= r_tx_idx + IDX_ONE;
              r_state    <= S_TX_START;
            end else if (r_src_addr == load_end_addr) begin
              r_load_done <= 1'b1;
              r_tmo       <= '0;
              r_state     <= S_DUMP;
            end else begin
              r_src_addr <= r_src_addr + ADDR_ONE;
              r_state    <= S_LD_ADDR;
            end
          end
        end
        S_DUMP: begin
          if (rxByteReady) begin
            r_tmo <= '0;
            for (int k = 0; k < BPW; k++) begin
              if (r_rx_idx == IW'(k)) r_rx_word[k*UART_WIDTH +: UART_WIDTH] <= byteFromRx;
            end
            if (r_rx_idx == LAST_IDX) begin
              r_rx_idx <= '0;
              r_state  <= S_CAP_WR;
            end else begin
              r_rx_idx <= r_rx_idx + IDX_ONE;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_ONE;
          end
        end
        S_CAP_WR: begin
          r_tmo <= '0;
          // An all-ones end address must stop here rather than wrap to 0.
          if (r_cap_addr == dump_end_addr) begin
            r_state <= S_IDLE;
          end else begin
            r_cap_addr <= r_cap_addr + ADDR_ONE;
            r_state    <= S_DUMP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so a reset landing on CAP_WR never writes.
  assign w_cap_wr    = (r_state == S_CAP_WR) && !rst;
  assign capWrEn     = w_cap_wr;
  assign dump_done   = w_cap_wr && (r_cap_addr == dump_end_addr);
  assign txByteStart = (r_state == S_TX_START) && txByteReady && !rst;
  assign busy        = (r_state != S_IDLE);
  assign load_done   = r_load_done;
  assign timeout_err = r_timeout_err;
  assign srcAddr     = r_src_addr;
  assign capAddr     = r_cap_addr;
  assign capData     = r_rx_word[MEM_WORD_LENGTH-1:0];
  assign byteForTx   = r_tx_shift[UART_WIDTH-1:0];
  assign dbg_state   = r_state;

  assign w_unused = ^{rx_new_byte_indicate, r_rx_word};

endmodule

// File: tb/tb_uart_mem_host.sv
// Directed bench for uart_mem_host: source RAM and UART TX models, byte-level
// RX driver, and a scoreboard of expected TX bytes and capture writes.
`timescale 1ns/1ps
module tb_uart_mem_host;
  localparam int MW          = 12;
  localparam int AW          = 12;
  localparam int UW          = 8;
  localparam int TMO         = 1000;
  localparam int TX_BUSY_CYC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_end_addr = '0;
  logic [AW-1:0] dump_end_addr = '0;
  logic          busy, load_done, dump_done, timeout_err;
  logic [AW-1:0] srcAddr, capAddr;
  logic [MW-1:0] srcData, capData;
  logic          capWrEn, txByteStart;
  logic          txByteReady = 1'b1;
  logic [UW-1:0] byteForTx;
  logic          rxByteReady = 1'b0;
  logic          rx_new_byte_indicate = 1'b0;
  logic [UW-1:0] byteFromRx = '0;
  logic [3:0]    dbg_state;

  uart_mem_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en),
    .load_end_addr(load_end_addr), .dump_end_addr(dump_end_addr),
    .busy(busy), .load_done(load_done), .dump_done(dump_done), .timeout_err(timeout_err),
    .srcAddr(srcAddr), .srcData(srcData),
    .capWrEn(capWrEn), .capAddr(capAddr), .capData(capData),
    .txByteReady(txByteReady), .txByteStart(txByteStart), .byteForTx(byteForTx),
    .rxByteReady(rxByteReady), .rx_new_byte_indicate(rx_new_byte_indicate),
    .byteFromRx(byteFromRx), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- source RAM, 2-cycle read latency ----------------
  logic [MW-1:0] src_mem [0:4095];
  logic [MW-1:0] rd_p1 = '0, rd_p2 = '0;
  always @(posedge clk) begin
    rd_p1 <= src_mem[srcAddr];
    rd_p2 <= rd_p1;
  end
  assign srcData = rd_p2;

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [UW-1:0] exp_tx_q[$];
  logic [UW-1:0] tx_log[$];
  logic [AW+MW-1:0] exp_cap_q[$];
  logic [MW-1:0] cap_mem [0:4095];
  int            ld_cnt = 0, dd_cnt = 0, wr_cnt = 0;
  logic [UW-1:0] tx_last = '0;
  logic          mdl_on = 1'b0;
  logic [AW-1:0] mdl_cap_addr = '0;
  logic [AW-1:0] cur_dump_end = '0;
  logic [UW-1:0] cmp_tx_e;
  logic [AW+MW-1:0] cmp_cap_e;
  logic [UW-1:0] lit_load4 [0:7] = '{8'h50, 8'h0A, 8'h51, 8'h0A, 8'h52, 8'h0A, 8'h53, 8'h0A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- UART TX model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (txByteStart && !rst) begin
        @(negedge clk);
        txByteReady = 1'b0;
        repeat (TX_BUSY_CYC) @(negedge clk);
        txByteReady = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mdl_on && !rst) begin
      if (txByteStart) begin
        tx_log.push_back(byteForTx);
        tx_last = byteForTx;
        if (exp_tx_q.size() > 0) cmp_tx_e = exp_tx_q.pop_front();
        else cmp_tx_e = 'x;
        check("tx_byte", byteForTx, cmp_tx_e);
      end
      if (busy && !txByteReady) check("tx_byte_hold", byteForTx, tx_last);
      if (load_done) begin
        ld_cnt++;
        check("load_done_after_last_byte", exp_tx_q.size(), 0);
      end
      if (dump_done) dd_cnt++;
      if (capWrEn) begin
        wr_cnt++;
        if (exp_cap_q.size() > 0) cmp_cap_e = exp_cap_q.pop_front();
        else cmp_cap_e = 'x;
        check("cap_addr", capAddr, cmp_cap_e[AW+MW-1:MW]);
        check("cap_data", capData, cmp_cap_e[MW-1:0]);
        check("dump_done_on_last_write", dump_done, cmp_cap_e[AW+MW-1:MW] == cur_dump_end);
        cap_mem[capAddr] = capData;
      end else if (dump_done) begin
        check("dump_done_without_write", dump_done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_load(input int last);
    for (int i = 0; i <= last; i++) begin
      logic [MW-1:0] w;
      w = src_mem[i];
      exp_tx_q.push_back(w[7:0]);
      exp_tx_q.push_back({4'b0, w[11:8]});
    end
  endtask

  task automatic start_session(input logic le, input logic [AW-1:0] lend, input logic [AW-1:0] dend);
    ld_cnt = 0; dd_cnt = 0; wr_cnt = 0;
    tx_log.delete();
    mdl_cap_addr = '0;
    cur_dump_end = dend;
    mdl_on = 1'b1;
    @(negedge clk);
    load_en = le; load_end_addr = lend; dump_end_addr = dend; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("timeout_err_cleared_by_start", timeout_err, 0);
    if (le) check("srcAddr_at_start", srcAddr, 0);
  endtask

  task automatic send_byte(input logic [UW-1:0] b, input logic exp_wr);
    @(negedge clk);
    rxByteReady = 1'b1; byteFromRx = b;
    @(negedge clk);
    rxByteReady = 1'b0;
    if (exp_wr) check("capwr_one_cycle_after_last_byte", capWrEn, 1);
  endtask

  task automatic send_word(input logic [UW-1:0] b0, input logic [UW-1:0] b1);
    logic [15:0] w;
    w = {b1, b0};
    exp_cap_q.push_back({mdl_cap_addr, w[MW-1:0]});
    mdl_cap_addr = mdl_cap_addr + 1'b1;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic wait_load_done(input int budget);
    int k;
    k = 0;
    while (load_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("load_done_seen", load_done, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_dump_done"}, dump_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_srcAddr"}, srcAddr, 0);
    check({tag, "_capWrEn"}, capWrEn, 0);
    check({tag, "_capAddr"}, capAddr, 0);
    check({tag, "_capData"}, capData, 0);
    check({tag, "_txByteStart"}, txByteStart, 0);
    check({tag, "_byteForTx"}, byteForTx, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic [MW-1:0] w;
    for (int i = 0; i < 4096; i++) src_mem[i] = MW'(i);
    for (int i = 0; i < 4; i++) src_mem[i] = MW'(12'hA50 + i);

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("reset");

    // load 4 words, then a 1-word dump; start and RX bytes injected mid-load are ignored
    push_load(3);
    start_session(1'b1, 12'd3, 12'd0);
    @(negedge clk); check("no_tx_strobe_cycle2", txByteStart, 0);
    @(negedge clk); check("no_tx_strobe_cycle3", txByteStart, 0);
    @(negedge clk); check("tx_strobe_cycle4", txByteStart, 1);
    check("first_tx_byte", byteForTx, 8'h50);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_byte(8'hEE, 1'b0);
    send_byte(8'h0E, 1'b0);
    check("no_write_during_load", wr_cnt, 0);
    wait_load_done(1000);
    send_word(8'h21, 8'h03);
    wait_idle(20);
    check("load_tx_count", tx_log.size(), 8);
    for (int i = 0; i < 8; i++) check("load_tx_literal", tx_log[i], lit_load4[i]);
    check("load_done_once", ld_cnt, 1);
    check("load_dump_done_once", dd_cnt, 1);
    check("load_dump_writes", wr_cnt, 1);
    check("load_cap0_literal", cap_mem[0], 12'h321);
    check("load_tx_q_drained", exp_tx_q.size(), 0);

    // dump-only, 2 words
    start_session(1'b0, 12'd0, 12'd1);
    send_word(8'h34, 8'hF2);
    send_word(8'hFF, 8'h0F);
    wait_idle(20);
    check("dump2_cap0_literal", cap_mem[0], 12'h234);
    check("dump2_cap1_literal", cap_mem[1], 12'hFFF);
    check("dump2_writes", wr_cnt, 2);
    check("dump2_dump_done_once", dd_cnt, 1);
    check("dump2_no_load_done", ld_cnt, 0);
    check("dump2_no_tx", tx_log.size(), 0);

    // timeout after a single byte
    start_session(1'b0, 12'd0, 12'd5);
    send_byte(8'h11, 1'b0);
    k = 0;
    while (k < 1100 && timeout_err !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 1000);
    check("timeout_busy_low", busy, 0);
    check("timeout_no_write", wr_cnt, 0);
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", timeout_err, 1);

    // reset while a byte is on the wire, then a clean load
    push_load(1);
    start_session(1'b1, 12'd1, 12'd0);
    k = 0;
    while (txByteReady === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midtx_tx_busy_reached", txByteReady, 0);
    mdl_on = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_outputs_zero("midtx_reset");
    exp_tx_q.delete();
    exp_cap_q.delete();
    k = 0;
    while (txByteReady !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    push_load(1);
    start_session(1'b1, 12'd1, 12'd0);
    wait_load_done(500);
    send_word(8'h5A, 8'h0C);
    wait_idle(20);
    check("reload_tx_count", tx_log.size(), 4);
    for (int i = 0; i < 4; i++) check("reload_tx_literal", tx_log[i], lit_load4[i]);
    check("reload_cap0_literal", cap_mem[0], 12'hC5A);
    check("reload_load_done_once", ld_cnt, 1);
    check("reload_dump_done_once", dd_cnt, 1);

    // full-range dump ending at the all-ones address
    start_session(1'b0, 12'd0, 12'hFFF);
    for (int i = 0; i < 4096; i++) begin
      w = MW'(i * 37 + 5);
      send_word(w[7:0], {4'(i), w[11:8]});
    end
    wait_idle(20);
    repeat (10) @(negedge clk);
    check("full_writes", wr_cnt, 4096);
    check("full_dump_done_once", dd_cnt, 1);
    check("full_cap0_literal", cap_mem[0], 12'h005);
    check("full_cap1_literal", cap_mem[1], 12'h02A);
    check("full_cap4095_literal", cap_mem[4095], 12'hFE0);
    check("full_capAddr_no_wrap", capAddr, 12'hFFF);
    check("full_cap_q_drained", exp_cap_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
